// File: rtl/sn_ttl_pkg.sv
// Shared definitions for the behavioural TTL parts: mode-select encodings
// and the supply-pin check that gates every state change.
package sn_ttl_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   // The part is live only with VCC high and GND low.
   function automatic logic pwr_ok(input logic vcc, input logic gnd);
      return vcc & ~gnd;
   endfunction

endpackage

// File: rtl/sn74x194_param.sv
// WIDTH-bit universal shift register (hold / shift right / shift left / load)
// with synchronous clear, power-pin gating and serial cascade outputs.
module sn74x194_param
   import sn_ttl_pkg::*;
#(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
   input  logic             CLK,
   input  logic             CLR_N,
   input  logic             VCC,
   input  logic             GND,
   input  logic [1:0]       S,
   input  logic [WIDTH-1:0] D,
   input  logic             SR_IN,
   input  logic             SL_IN,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Q_N,
   output logic             SR_OUT,
   output logic             SL_OUT
);

   // Unpowered edges leave Q untouched, clear included. An X/Z on CLR_N or S
   // falls through to the default arms and poisons Q to flag floating pins.
   always_ff @(posedge CLK) begin
      if (pwr_ok(VCC, GND)) begin
         case (CLR_N)
            1'b0: Q <= CLR_VALUE;
            1'b1: begin
               case (S)
                  MODE_HOLD: Q <= Q;
                  MODE_SHR:  Q <= {SR_IN, Q[WIDTH-1:1]};
                  MODE_SHL:  Q <= {Q[WIDTH-2:0], SL_IN};
                  MODE_LOAD: Q <= D;
                  default:   Q <= 'x;
               endcase
            end
            default: Q <= 'x;
         endcase
      end
   end

   assign Q_N    = ~Q;
   assign SR_OUT = Q[0];
   assign SL_OUT = Q[WIDTH-1];

endmodule

// File: tb/tb_sn74x194_param.sv
// Directed bench for sn74x194_param: a 4-bit part for the mode tests and two
// chained 8-bit parts (nonzero clear value) for the cascade test.
module tb_sn74x194_param;

   logic       clk;
   logic       clr_n, vcc, gnd, sr_in, sl_in;
   logic [1:0] s;
   logic [3:0] d;
   logic [3:0] q, q_n;
   logic       sr_out, sl_out;

   logic       c_clr_n, a_sr_in, b_sl_in;
   logic [1:0] c_s;
   logic [7:0] c_d, a_q, a_q_n, b_q, b_q_n;
   logic       a_sr_out, a_sl_out, b_sr_out, b_sl_out;

   int n_cmp = 0;
   int n_err = 0;

   sn74x194_param #(.WIDTH(4), .CLR_VALUE(4'b0000)) dut (
      .CLK(clk), .CLR_N(clr_n), .VCC(vcc), .GND(gnd), .S(s), .D(d),
      .SR_IN(sr_in), .SL_IN(sl_in), .Q(q), .Q_N(q_n),
      .SR_OUT(sr_out), .SL_OUT(sl_out)
   );

   // A feeds B on the right-shift path; B feeds A on the left-shift path.
   sn74x194_param #(.WIDTH(8), .CLR_VALUE(8'hA5)) dut_a (
      .CLK(clk), .CLR_N(c_clr_n), .VCC(1'b1), .GND(1'b0), .S(c_s), .D(c_d),
      .SR_IN(a_sr_in), .SL_IN(b_sl_out), .Q(a_q), .Q_N(a_q_n),
      .SR_OUT(a_sr_out), .SL_OUT(a_sl_out)
   );

   sn74x194_param #(.WIDTH(8), .CLR_VALUE(8'hA5)) dut_b (
      .CLK(clk), .CLR_N(c_clr_n), .VCC(1'b1), .GND(1'b0), .S(c_s), .D(c_d),
      .SR_IN(a_sr_out), .SL_IN(b_sl_in), .Q(b_q), .Q_N(b_q_n),
      .SR_OUT(b_sr_out), .SL_OUT(b_sl_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic test_reset();
      clr_n = 1'b0; s = 2'b00; d = 4'b0000;
      step();
      chk4("reset_q", q, 4'b0000);
      chk4("reset_q_n", q_n, 4'b1111);
      s = 2'b11; d = 4'b1010;
      step();
      chk4("clear_beats_load", q, 4'b0000);
   endtask

   task automatic test_load_hold();
      clr_n = 1'b1; s = 2'b11; d = 4'b1011;
      step();
      chk4("load_q", q, 4'b1011);
      chk4("load_q_n", q_n, 4'b0100);
      s = 2'b00; d = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         step();
         chk4($sformatf("hold_%0d", i), q, 4'b1011);
      end
   endtask

   task automatic test_shift_right();
      logic [3:0] exp_q [3];
      logic       exp_so [3];
      logic       sin [3];
      exp_q = '{4'b1101, 4'b0110, 4'b0011};
      exp_so = '{1'b1, 1'b1, 1'b0};
      sin = '{1'b1, 1'b0, 1'b0};
      s = 2'b01;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (sr_out !== exp_so[i]) begin
            n_err++;
            $display("FAIL shr_sr_out_%0d: got %b expected %b", i, sr_out, exp_so[i]);
         end
         sr_in = sin[i];
         step();
         chk4($sformatf("shr_q_%0d", i), q, exp_q[i]);
      end
   endtask

   task automatic test_shift_left();
      logic [3:0] exp_q [2];
      logic       exp_so [2];
      exp_q = '{4'b0111, 4'b1111};
      exp_so = '{1'b0, 1'b1};
      s = 2'b10; sl_in = 1'b1; sr_in = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         chk4($sformatf("shl_q_%0d", i), q, exp_q[i]);
         n_cmp++;
         if (sl_out !== exp_so[i]) begin
            n_err++;
            $display("FAIL shl_sl_out_%0d: got %b expected %b", i, sl_out, exp_so[i]);
         end
      end
   endtask

   task automatic test_power();
      clr_n = 1'b1; s = 2'b11; d = 4'b0101;
      step();
      chk4("pwr_preload", q, 4'b0101);
      gnd = 1'b1; clr_n = 1'b0; s = 2'b11; d = 4'b1111;
      for (int i = 0; i < 2; i++) begin
         step();
         chk4($sformatf("gnd_gated_%0d", i), q, 4'b0101);
      end
      gnd = 1'b0; vcc = 1'b0;
      step();
      chk4("vcc_gated", q, 4'b0101);
      vcc = 1'b1; clr_n = 1'b1; s = 2'b00;
      step();
      chk4("pwr_restored_hold", q, 4'b0101);
      s = 2'b10; sl_in = 1'b0;
      step();
      chk4("pwr_resume_shl", q, 4'b1010);
   endtask

   task automatic test_cascade();
      c_clr_n = 1'b0; c_s = 2'b11; c_d = 8'h00; a_sr_in = 1'b0; b_sl_in = 1'b0;
      step();
      n_cmp++;
      if (a_q !== 8'hA5 || b_q !== 8'hA5) begin
         n_err++;
         $display("FAIL casc_clear: got A=%h B=%h expected A5 A5", a_q, b_q);
      end
      c_clr_n = 1'b1; c_d = 8'h80;
      step();
      c_s = 2'b01;
      for (int i = 0; i < 9; i++) step();
      n_cmp++;
      if (b_q !== 8'h40) begin
         n_err++;
         $display("FAIL casc_b_q: got %h expected 40", b_q);
      end
      n_cmp++;
      if (a_q !== 8'h00) begin
         n_err++;
         $display("FAIL casc_a_q: got %h expected 00", a_q);
      end
      // Shift back left: B's top bit (0) enters A, B takes zero from its own SL_IN.
      c_s = 2'b10;
      step();
      n_cmp++;
      if (a_q !== 8'h00 || b_q !== 8'h80) begin
         n_err++;
         $display("FAIL casc_shl: got A=%h B=%h expected 00 80", a_q, b_q);
      end
      step();
      n_cmp++;
      if (a_q !== 8'h01 || b_q !== 8'h00) begin
         n_err++;
         $display("FAIL casc_shl_carry: got A=%h B=%h expected 01 00", a_q, b_q);
      end
   endtask

   initial begin
      vcc = 1'b1; gnd = 1'b0; clr_n = 1'b1; s = 2'b00; d = 4'b0000;
      sr_in = 1'b0; sl_in = 1'b0;
      c_clr_n = 1'b1; c_s = 2'b00; c_d = 8'h00; a_sr_in = 1'b0; b_sl_in = 1'b0;
      #2;
      test_reset();
      test_load_hold();
      test_shift_right();
      test_shift_left();
      test_power();
      test_cascade();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sn74x194_param.md
Name: sn74x194_param

Overview:
- Parametrised successor to the team's dual D flip-flop TTL model: a WIDTH-bit universal register.
- Modes: hold, shift-right, shift-left, parallel load.
- Provides serial in/out on both ends, true and complement outputs, and power-pin gating.
- Used as a drop-in behavioural part in board-level TTL netlists that need wider or cascadable storage than discrete D FFs.

Parameters:
- WIDTH, 4: register width in bits; legal values 2..32.
- CLR_VALUE, 0: value loaded into Q on synchronous clear; WIDTH bits wide.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- CLR_N  input  1  synchronous active-low clear.
- VCC  input  1  supply pin; the part operates only when VCC==1.
- GND  input  1  ground pin; the part operates only when GND==0.
- S  input  2  mode select: 00 hold, 01 shift right, 10 shift left, 11 load.
- D  input  WIDTH  parallel data, used in load mode.
- SR_IN  input  1  serial input, shifted into bit WIDTH-1 in shift-right mode.
- SL_IN  input  1  serial input, shifted into bit 0 in shift-left mode.
- Q  output  WIDTH  register contents.
- Q_N  output  WIDTH  bitwise complement of Q.
- SR_OUT  output  1  equals Q[0], for cascading to the next stage's SR_IN.
- SL_OUT  output  1  equals Q[WIDTH-1], for cascading to the next stage's SL_IN.

Behaviour:
- One clock domain, CLK. All updates occur on the rising edge of CLK only. No asynchronous paths.
- Power valid (PV) means VCC==1 && GND==0. If PV is false at a rising edge, Q holds; this applies to clear as well.
- Reset is synchronous and active-low. At a rising edge with PV and CLR_N==0: Q <= CLR_VALUE, regardless of S.
- Clear has priority over every mode. There is no reset state other than CLR_VALUE.
- At a rising edge with PV and CLR_N==1:
  - S=00 (hold): Q unchanged.
  - S=01 (shift right): Q <= {SR_IN, Q[WIDTH-1:1]}. Bit 0 is discarded.
  - S=10 (shift left): Q <= {Q[WIDTH-2:0], SL_IN}. Bit WIDTH-1 is discarded.
  - S=11 (load): Q <= D.
- X or Z on S with PV and CLR_N==1: Q <= all-X, to flag floating select pins. X on CLR_N likewise gives all-X.
- Latency: Q reflects the new value in the same timestep as the edge (non-blocking update). Q_N, SR_OUT and SL_OUT are continuous functions of Q with zero latency.
- Q is X from power-up until the first valid clear or load. No initial block; this matches real part behaviour.
- Simultaneous events:
  - CLR_N deasserted and S=11 on the same edge: the clear is still sampled low, so Q=CLR_VALUE.
  - The next edge applies the mode.
- Power loss mid-operation: Q holds its last value. When PV returns, operation resumes from the held value with no implicit clear.
- Wrap-around: none. Shifts are not rotates. A rotate is built externally by tying SR_OUT to SR_IN.
- Cascading: two instances chained through SR_OUT/SL_OUT behave as one 2*WIDTH register under a shared S and CLK.

Decomposition:
- Shared package sn_ttl_pkg holds:
  - mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11;
  - the power-valid check as a function pwr_ok(vcc, gnd).
- No sub-module. A single always block for the next-state mux plus continuous assigns for Q_N, SR_OUT and SL_OUT.
- A fixed-pin 16-pin wrapper (sn74194, WIDTH=4) is written later as a separate file.

Test Plan:
- Clear: WIDTH=4, CLR_VALUE=0, Q=X; CLR_N=0 for one edge → Q=0000, Q_N=1111. With S=11, D=1010, CLR_N=0 → Q stays 0000.
- Load/hold: CLR_N=1, S=11, D=1011, one edge → Q=1011. S=00 for 3 edges with D=0000 → Q=1011.
- Shift right: Q=1011, S=01, SR_IN sequence 1,0,0 → Q=1101, 0110, 0011. SR_OUT before each edge is 1, 1, 0.
- Shift left: Q=0011, S=10, SL_IN=1 for 2 edges → Q=0111, then 1111. SL_OUT after the edges is 0, 1.
- Power gating: Q=0101, GND=1, then CLR_N=0 and S=11 with D=1111 for 2 edges → Q=0101. Restore GND=0, S=00 → Q=0101.
- Cascade: two WIDTH=8 instances (A's SR_OUT feeds B's SR_IN), both loaded with 8'h80, A's SR_IN=0, S=01 for 9 edges → B.Q=8'h40, A.Q=8'h00.
